dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 (pipeline) has fixed priority, port 1 (loader/debug)
// is forced through after STARVE_LIMIT waiting cycles. Illegal accesses are blocked and flagged.
module dmem_arbiter #(
   parameter logic [31:0] START_ADDR   = 32'h0100_0000,
   parameter logic [31:0] MEM_BYTES    = 32'h0010_0000,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [1:0]  p0_size,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_gnt,
   output logic        p0_rvalid,
   output logic        p0_err,
   output logic [31:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [1:0]  p1_size,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_gnt,
   output logic        p1_rvalid,
   output logic        p1_err,
   output logic [31:0] p1_rdata,
   output logic [31:0] mem_address,
   output logic        mem_read_write,
   output logic [1:0]  mem_access_size,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out
);

   localparam int unsigned    CW       = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0]  LIMIT    = CW'(STARVE_LIMIT);
   localparam logic [32:0]    END_ADDR = {1'b0, START_ADDR} + {1'b0, MEM_BYTES};

   logic        w_req   [2];
   logic        w_we    [2];
   logic [1:0]  w_size  [2];
   logic [31:0] w_addr  [2];
   logic [31:0] w_wdata [2];
   logic        w_gnt   [2];
   logic        w_legal [2];
   logic        r_rvalid[2];
   logic        r_err   [2];
   logic [31:0] r_rdata [2];

   logic [CW-1:0] r_starve_cnt;
   logic          w_force_p1;
   logic          w_p1_wins;

   assign w_req[0]   = p0_req;
   assign w_we[0]    = p0_we;
   assign w_size[0]  = p0_size;
   assign w_addr[0]  = p0_addr;
   assign w_wdata[0] = p0_wdata;
   assign w_req[1]   = p1_req;
   assign w_we[1]    = p1_we;
   assign w_size[1]  = p1_size;
   assign w_addr[1]  = p1_addr;
   assign w_wdata[1] = p1_wdata;

   // Grants are gated by reset so nothing is accepted while it is held.
   assign w_force_p1 = (r_starve_cnt >= LIMIT);
   assign w_p1_wins  = !reset && w_req[1] && (!w_req[0] || w_force_p1);
   assign w_gnt[0]   = !reset && w_req[0] && !w_p1_wins;
   assign w_gnt[1]   = w_p1_wins;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_starve_cnt <= '0;
      end else if (w_gnt[1] || !w_req[1]) begin
         r_starve_cnt <= '0;
      end else if (r_starve_cnt < LIMIT) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         logic [2:0] w_bytes;
         logic       w_align_ok;
         logic       w_range_ok;

         always_comb begin
            case (w_size[gi])
               2'd0:    w_bytes = 3'd1;
               2'd1:    w_bytes = 3'd2;
               default: w_bytes = 3'd4;
            endcase
         end

         // Size code 3 matches none of the alignment terms, so it falls out as illegal here.
         assign w_align_ok = (w_size[gi] == 2'd0) ||
                             (w_size[gi] == 2'd1 && !w_addr[gi][0]) ||
                             (w_size[gi] == 2'd2 && w_addr[gi][1:0] == 2'b00);
         assign w_range_ok = (w_addr[gi] >= START_ADDR) &&
                             (({1'b0, w_addr[gi]} + {30'd0, w_bytes}) <= END_ADDR);
         assign w_legal[gi] = w_align_ok && w_range_ok;

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               r_rvalid[gi] <= 1'b0;
               r_err[gi]    <= 1'b0;
               r_rdata[gi]  <= '0;
            end else begin
               r_rvalid[gi] <= w_gnt[gi] && !w_we[gi] && w_legal[gi];
               r_err[gi]    <= w_gnt[gi] && !w_legal[gi];
               if (w_gnt[gi] && !w_we[gi] && w_legal[gi]) begin
                  r_rdata[gi] <= mem_data_out;
               end
            end
         end
      end
   endgenerate

   always_comb begin
      mem_address     = 32'd0;
      mem_read_write  = 1'b0;
      mem_access_size = 2'd2;
      mem_data_in     = 32'd0;
      if (w_gnt[0]) begin
         mem_address     = w_addr[0];
         mem_read_write  = w_we[0] && w_legal[0];
         mem_access_size = w_size[0];
         mem_data_in     = w_wdata[0];
      end else if (w_gnt[1]) begin
         mem_address     = w_addr[1];
         mem_read_write  = w_we[1] && w_legal[1];
         mem_access_size = w_size[1];
         mem_data_in     = w_wdata[1];
      end
   end

   assign p0_gnt    = w_gnt[0];
   assign p0_rvalid = r_rvalid[0];
   assign p0_err    = r_err[0];
   assign p0_rdata  = r_rdata[0];
   assign p1_gnt    = w_gnt[1];
   assign p1_rvalid = r_rvalid[1];
   assign p1_err    = r_err[1];
   assign p1_rdata  = r_rdata[1];

endmodule
